// File: rtl/thermocouple_pkg.sv
// Shared types and frame layout for the thermocouple converter front-ends.
// Pure definitions: no latency, no flow control.
package thermocouple_pkg;

    typedef enum logic [2:0] {
        STARTUP = 3'd0,
        REQ     = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        CAPTURE = 3'd4,
        TIMEOUT = 3'd5,
        GAP     = 3'd6
    } state_t;

    localparam int FRAME_W = 32;
    localparam int TC_W    = 14;
    localparam int JN_W    = 12;
    localparam int FLT_W   = 4;

    localparam int TC_MSB  = 31;
    localparam int TC_LSB  = 18;
    localparam int JN_MSB  = 15;
    localparam int JN_LSB  = 4;
    localparam int OC_BIT  = 16;
    localparam int ERR_MSB = 2;

    localparam logic [FLT_W-1:0] FAULT_TIMEOUT = 4'b1111;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tc_frame_decode.sv
// Splits a 32-bit converter frame into thermocouple, junction and fault fields.
// Purely combinational, zero latency, no flow control.
module tc_frame_decode
    import thermocouple_pkg::*;
(
    input  logic [FRAME_W-1:0] i_frame,
    output logic [TC_W-1:0]    o_tc,
    output logic [JN_W-1:0]    o_jn,
    output logic [FLT_W-1:0]   o_fault
);

    // Bits 17 and 3 are reserved in the converter frame.
    logic w_unused_bits;

    assign o_tc          = i_frame[TC_MSB:TC_LSB];
    assign o_jn          = i_frame[JN_MSB:JN_LSB];
    assign o_fault       = {i_frame[OC_BIT], i_frame[ERR_MSB:0]};
    assign w_unused_bits = ^{i_frame[17], i_frame[3]};

endmodule

// File: rtl/thermocouple_scanner.sv
// Round-robin thermocouple poller over a shared SPI master; TC_ALARM_EN adds per-channel over-limit alarms.
// Registers update and sample_valid pulses 1 clk after spi_busy falls; no backpressure, SPI master paces, TIMEOUT_CYC bounds a stuck transfer.
module thermocouple_scanner
    import thermocouple_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int STARTUP_CYC = 12000,
    parameter int PERIOD_CYC  = 4000,
    parameter int TIMEOUT_CYC = 255,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
`ifdef TC_ALARM_EN
    , parameter logic signed [TC_W-1:0] ALARM_LIMIT = 14'sd4000
`endif
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_spi_start,
    output logic [CH_W-1:0]          o_spi_ch,
    input  logic                     i_spi_busy,
    input  logic [FRAME_W-1:0]       i_spi_rx_data,
    output logic [TC_W*NUM_CH-1:0]   o_tc_temp,
    output logic [JN_W*NUM_CH-1:0]   o_jn_temp,
    output logic [FLT_W*NUM_CH-1:0]  o_fault,
    output logic                     o_sample_valid,
    output logic [CH_W-1:0]          o_sample_ch
`ifdef TC_ALARM_EN
    , output logic [NUM_CH-1:0]      o_alarm
`endif
);

    localparam int CNT_W = $clog2(max3(STARTUP_CYC, PERIOD_CYC, TIMEOUT_CYC) + 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CH_W-1:0]           r_ptr;
    logic [TC_W*NUM_CH-1:0]    r_tc;
    logic [JN_W*NUM_CH-1:0]    r_jn;
    logic [FLT_W*NUM_CH-1:0]   r_flt;

    logic [TC_W-1:0]           w_tc;
    logic [JN_W-1:0]           w_jn;
    logic [FLT_W-1:0]          w_flt;
    logic                      w_timed_out;
    logic                      w_do_cap;
    logic                      w_do_tmo;
    logic                      w_cnt_keep;

    tc_frame_decode u_decode (
        .i_frame (i_spi_rx_data),
        .o_tc    (w_tc),
        .o_jn    (w_jn),
        .o_fault (w_flt)
    );

    assign w_timed_out = (r_cnt == CNT_W'(TIMEOUT_CYC));
    assign w_do_cap    = (r_state == WAIT_LO) && (w_state_nxt == CAPTURE);
    assign w_do_tmo    = (w_state_nxt == TIMEOUT);
    // The timeout budget spans the whole transfer, so WAIT_HI -> WAIT_LO keeps counting.
    assign w_cnt_keep  = (w_state_nxt == r_state) ||
                         ((r_state == WAIT_HI) && (w_state_nxt == WAIT_LO));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= STARTUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            STARTUP: if (r_cnt == CNT_W'(STARTUP_CYC)) w_state_nxt = REQ;
            REQ:     w_state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (i_spi_busy)       w_state_nxt = WAIT_LO;
                else if (w_timed_out) w_state_nxt = TIMEOUT;
            end
            WAIT_LO: begin
                if (!i_spi_busy)      w_state_nxt = CAPTURE;
                else if (w_timed_out) w_state_nxt = TIMEOUT;
            end
            CAPTURE: w_state_nxt = GAP;
            TIMEOUT: w_state_nxt = GAP;
            GAP:     if (r_cnt == CNT_W'(PERIOD_CYC)) w_state_nxt = REQ;
            default: w_state_nxt = GAP;
        endcase
    end

    always_comb begin
        o_spi_start    = (r_state == REQ);
        o_sample_valid = (r_state == CAPTURE) || (r_state == TIMEOUT);
        o_spi_ch       = r_ptr;
        o_sample_ch    = r_ptr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt <= '0;
            r_ptr <= '0;
        end else begin
            r_cnt <= w_cnt_keep ? r_cnt + CNT_W'(1) : '0;
            if ((r_state == GAP) && (w_state_nxt == REQ)) begin
                r_ptr <= (r_ptr == CH_W'(NUM_CH - 1)) ? '0 : r_ptr + CH_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_tc  <= '0;
            r_jn  <= '0;
            r_flt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_ptr == CH_W'(i)) begin
                    if (w_do_cap) begin
                        r_tc[i*TC_W +: TC_W]    <= w_tc;
                        r_jn[i*JN_W +: JN_W]    <= w_jn;
                        r_flt[i*FLT_W +: FLT_W] <= w_flt;
                    end else if (w_do_tmo) begin
                        r_flt[i*FLT_W +: FLT_W] <= FAULT_TIMEOUT;
                    end
                end
            end
        end
    end

    assign o_tc_temp = r_tc;
    assign o_jn_temp = r_jn;
    assign o_fault   = r_flt;

`ifdef TC_ALARM_EN
    logic [NUM_CH-1:0] r_alarm;
    logic              w_over;

    // An open-circuit frame carries a meaningless temperature, so it never alarms.
    assign w_over = ($signed(w_tc) > ALARM_LIMIT) && !w_flt[FLT_W-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_alarm <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_ptr == CH_W'(i)) begin
                    if (w_do_cap)      r_alarm[i] <= w_over;
                    else if (w_do_tmo) r_alarm[i] <= 1'b0;
                end
            end
        end
    end

    assign o_alarm = r_alarm;
`endif

endmodule

// File: tb/tb_thermocouple_scanner.sv
// Directed bench for thermocouple_scanner: 3 channels, short startup/period/timeout.
// Expected values are hand-decoded from the frames below.
module tb_thermocouple_scanner;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 spi_start;
    logic [CH_W-1:0]      spi_ch;
    logic                 spi_busy = 1'b0;
    logic [31:0]          spi_rx_data = 32'h0;
    logic [14*NUM_CH-1:0] tc_temp;
    logic [12*NUM_CH-1:0] jn_temp;
    logic [4*NUM_CH-1:0]  fault;
    logic                 sample_valid;
    logic [CH_W-1:0]      sample_ch;
`ifdef TC_ALARM_EN
    logic [NUM_CH-1:0]    alarm;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    thermocouple_scanner #(
        .NUM_CH      (NUM_CH),
        .STARTUP_CYC (12),
        .PERIOD_CYC  (4),
        .TIMEOUT_CYC (8)
`ifdef TC_ALARM_EN
        , .ALARM_LIMIT (14'sd100)
`endif
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_spi_start    (spi_start),
        .o_spi_ch       (spi_ch),
        .i_spi_busy     (spi_busy),
        .i_spi_rx_data  (spi_rx_data),
        .o_tc_temp      (tc_temp),
        .o_jn_temp      (jn_temp),
        .o_fault        (fault),
        .o_sample_valid (sample_valid),
        .o_sample_ch    (sample_ch)
`ifdef TC_ALARM_EN
        , .o_alarm      (alarm)
`endif
    );

    task automatic wait_start(output int k);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!spi_start && k < 200);
    endtask

    // Plays the SPI master for one transfer; entered the cycle spi_start is high.
    task automatic xfer(input logic [31:0] frame, input logic [CH_W-1:0] ch);
        spi_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        spi_busy    = 1'b0;
        spi_rx_data = frame;
        @(posedge clk); #1;
        spi_rx_data = 32'hDEAD_BEEF;
        n_total++;
        if (sample_valid !== 1'b1 || sample_ch !== ch)
            $display("FAIL xfer_strobe: valid=%0b ch=%0d, expected valid=1 ch=%0d", sample_valid, sample_ch, ch);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (sample_valid !== 1'b0)
            $display("FAIL xfer_pulse_width: valid=%0b, expected 0", sample_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        int k;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({spi_start, spi_ch, sample_valid, sample_ch} !== '0 || tc_temp !== '0 ||
            jn_temp !== '0 || fault !== '0)
            $display("FAIL reset_outputs: start=%0b ch=%0d sv=%0b sch=%0d tc=%h jn=%h flt=%h, expected all 0",
                     spi_start, spi_ch, sample_valid, sample_ch, tc_temp, jn_temp, fault);
        else n_pass++;
        rst = 1'b1;
        wait_start(k);
        n_total++;
        if (k !== 13) $display("FAIL startup_latency: %0d cycles, expected 13", k);
        else n_pass++;
        n_total++;
        if (spi_ch !== 2'd0) $display("FAIL first_ch: %0d, expected 0", spi_ch);
        else n_pass++;
    endtask

    task automatic test_frame();
        xfer(32'hABCD_5678, 2'd0);
        n_total++;
        if (tc_temp[13:0] !== 14'h2AF3 || jn_temp[11:0] !== 12'h567 || fault[3:0] !== 4'b1000)
            $display("FAIL decode_ch0: tc=%h jn=%h flt=%b, expected 2af3/567/1000",
                     tc_temp[13:0], jn_temp[11:0], fault[3:0]);
        else n_pass++;
        n_total++;
        if (tc_temp[41:14] !== '0 || jn_temp[35:12] !== '0 || fault[11:4] !== '0)
            $display("FAIL others_hold: tc=%h jn=%h flt=%h, expected 0",
                     tc_temp[41:14], jn_temp[35:12], fault[11:4]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int k;
        wait_start(k);
        n_total++;
        if (k !== 5 || spi_ch !== 2'd1) $display("FAIL gap_ch1: k=%0d ch=%0d, expected 5/1", k, spi_ch);
        else n_pass++;
        xfer(32'h1234_5673, 2'd1);
        n_total++;
        if (tc_temp[27:14] !== 14'h048D || jn_temp[23:12] !== 12'h567 || fault[7:4] !== 4'b0011 ||
            tc_temp[13:0] !== 14'h2AF3)
            $display("FAIL decode_ch1: tc=%h jn=%h flt=%b ch0tc=%h, expected 048d/567/0011/2af3",
                     tc_temp[27:14], jn_temp[23:12], fault[7:4], tc_temp[13:0]);
        else n_pass++;
        wait_start(k);
        n_total++;
        if (spi_ch !== 2'd2) $display("FAIL seq_ch2: %0d, expected 2", spi_ch);
        else n_pass++;
        xfer(32'hFFFC_0007, 2'd2);
        n_total++;
        if (tc_temp[41:28] !== 14'h3FFF || jn_temp[35:24] !== 12'h000 || fault[11:8] !== 4'b0111)
            $display("FAIL decode_ch2: tc=%h jn=%h flt=%b, expected 3fff/000/0111",
                     tc_temp[41:28], jn_temp[35:24], fault[11:8]);
        else n_pass++;
        wait_start(k);
        n_total++;
        if (spi_ch !== 2'd0) $display("FAIL wrap_ch0: %0d, expected 0", spi_ch);
        else n_pass++;
        xfer(32'h0004_0010, 2'd0);
        n_total++;
        if (tc_temp[13:0] !== 14'h0001 || jn_temp[11:0] !== 12'h001 || fault[3:0] !== 4'b0000)
            $display("FAIL decode_ch0_again: tc=%h jn=%h flt=%b, expected 0001/001/0000",
                     tc_temp[13:0], jn_temp[11:0], fault[3:0]);
        else n_pass++;
        n_total++;
        if (tc_temp[27:14] !== 14'h048D || jn_temp[23:12] !== 12'h567 || fault[7:4] !== 4'b0011 ||
            tc_temp[41:28] !== 14'h3FFF || fault[11:8] !== 4'b0111)
            $display("FAIL ch1_ch2_hold: tc1=%h jn1=%h f1=%b tc2=%h f2=%b",
                     tc_temp[27:14], jn_temp[23:12], fault[7:4], tc_temp[41:28], fault[11:8]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int k;
        wait_start(k);
        n_total++;
        if (spi_ch !== 2'd1) $display("FAIL tmo_ch: %0d, expected 1", spi_ch);
        else n_pass++;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!sample_valid && k < 100);
        n_total++;
        if (k !== 10 || sample_ch !== 2'd1)
            $display("FAIL tmo_latency: k=%0d ch=%0d, expected 10/1", k, sample_ch);
        else n_pass++;
        n_total++;
        if (fault[7:4] !== 4'b1111 || tc_temp[27:14] !== 14'h048D || jn_temp[23:12] !== 12'h567 ||
            fault[3:0] !== 4'b0000 || fault[11:8] !== 4'b0111)
            $display("FAIL tmo_regs: f1=%b tc1=%h jn1=%h f0=%b f2=%b, expected 1111/048d/567/0000/0111",
                     fault[7:4], tc_temp[27:14], jn_temp[23:12], fault[3:0], fault[11:8]);
        else n_pass++;
        // Busy high throughout GAP must not disturb the period or the pointer.
        spi_busy = 1'b1;
        wait_start(k);
        n_total++;
        if (k !== 6 || spi_ch !== 2'd2)
            $display("FAIL gap_busy_ignored: k=%0d ch=%0d, expected 6/2", k, spi_ch);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        int sv_seen;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({spi_start, spi_ch, sample_valid, sample_ch} !== '0 || tc_temp !== '0 ||
            jn_temp !== '0 || fault !== '0)
            $display("FAIL midreset_outputs: start=%0b ch=%0d sv=%0b tc=%h jn=%h flt=%h, expected all 0",
                     spi_start, spi_ch, sample_valid, tc_temp, jn_temp, fault);
        else n_pass++;
        rst = 1'b1;
        k = 0;
        sv_seen = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                spi_busy    = 1'b0;
                spi_rx_data = 32'h7FFF_FFFF;
            end
            if (sample_valid) sv_seen++;
        end while (!spi_start && k < 200);
        n_total++;
        if (sv_seen !== 0 || fault !== '0)
            $display("FAIL stale_busy_fall: strobes=%0d flt=%h, expected 0/0", sv_seen, fault);
        else n_pass++;
        n_total++;
        if (k !== 13 || spi_ch !== 2'd0)
            $display("FAIL restart_latency: k=%0d ch=%0d, expected 13/0", k, spi_ch);
        else n_pass++;
    endtask

`ifdef TC_ALARM_EN
    task automatic test_alarm();
        int k;
        xfer(32'h0194_0000, 2'd0);
        n_total++;
        if (alarm[0] !== 1'b1) $display("FAIL alarm_over: %0b, expected 1", alarm[0]);
        else n_pass++;
        wait_start(k);
        xfer(32'h0000_0000, 2'd1);
        wait_start(k);
        xfer(32'h0000_0000, 2'd2);
        wait_start(k);
        xfer(32'h0190_0000, 2'd0);
        n_total++;
        if (alarm[0] !== 1'b0) $display("FAIL alarm_at_limit: %0b, expected 0", alarm[0]);
        else n_pass++;
    endtask
`endif

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d", n_pass);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_round_robin();
        test_timeout();
        test_reset_mid();
`ifdef TC_ALARM_EN
        test_alarm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
